// File: rtl/hfir_line_feeder.sv
// Line feeder for a 3-tap horizontal FIR: emits each raster line as IMG_WIDTH+2 beats,
// repeating the first and last pixel so the filter sees both edges.
module hfir_line_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] center_o,
  output logic                  sol_o,
  output logic                  eol_o,
  output logic                  eof_o
);

  // state   | meaning
  // S_FIRST | waiting for the first pixel of a line (emitted as the left pad, sol)
  // S_REP_L | re-emitting the first pixel as the real column 0
  // S_PASS  | streaming pixels 1 .. IMG_WIDTH-1
  // S_PAD_R | re-emitting the last pixel as the right pad (eol, eof on last line)
  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_REP_L = 2'd1,
    S_PASS  = 2'd2,
    S_PAD_R = 2'd3
  } state_t;

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH + 1)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT + 1) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t                state;
  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  slot_free;
  logic                  accept;

  assign slot_free = !valid_o || ready_i;
  assign s_ready_o = slot_free && ((state == S_FIRST) || (state == S_PASS));
  assign accept    = s_valid_i && s_ready_o;

  // The whole register set only advances when the output slot is free, so a
  // downstream stall freezes every output and the FSM together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FIRST;
      col_cnt  <= '0;
      row_cnt  <= '0;
      hold_r   <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
      center_o <= '0;
      sol_o    <= 1'b0;
      eol_o    <= 1'b0;
      eof_o    <= 1'b0;
    end else if (slot_free) begin
      valid_o <= 1'b0;
      sol_o   <= 1'b0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
      case (state)
        S_FIRST: begin
          if (accept) begin
            valid_o  <= 1'b1;
            data_o   <= s_data_i;
            center_o <= s_data_i;
            hold_r   <= s_data_i;
            sol_o    <= 1'b1;
            col_cnt  <= CW'(1);
            state    <= S_REP_L;
          end
        end
        S_REP_L: begin
          valid_o  <= 1'b1;
          data_o   <= hold_r;
          center_o <= hold_r;
          if (IMG_WIDTH == 1) state <= S_PAD_R;
          else                state <= S_PASS;
        end
        S_PASS: begin
          if (accept) begin
            valid_o  <= 1'b1;
            data_o   <= s_data_i;
            center_o <= s_data_i;
            hold_r   <= s_data_i;
            col_cnt  <= col_cnt + CW'(1);
            if (col_cnt == COL_LAST) state <= S_PAD_R;
          end
        end
        S_PAD_R: begin
          valid_o  <= 1'b1;
          data_o   <= hold_r;
          center_o <= hold_r;
          eol_o    <= 1'b1;
          col_cnt  <= '0;
          if (row_cnt == ROW_LAST) begin
            eof_o   <= 1'b1;
            row_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
          state <= S_FIRST;
        end
        default: state <= S_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_hfir_line_feeder.sv
// Directed bench for hfir_line_feeder: W=4/H=2 main instance plus a W=1/H=1 instance.
module tb_hfir_line_feeder;

  logic       clk;
  logic       rst_n;
  logic       s_valid_i, s_ready_o, valid_o, ready_i, sol_o, eol_o, eof_o;
  logic [7:0] s_data_i, data_o, center_o;
  logic       s_valid1, s_ready1, valid1, sol1, eol1, eof1;
  logic [7:0] s_data1, data1, center1;

  int passed = 0;
  int total  = 0;

  hfir_line_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .center_o(center_o),
    .sol_o(sol_o), .eol_o(eol_o), .eof_o(eof_o)
  );

  hfir_line_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid1), .s_ready_o(s_ready1), .s_data_i(s_data1),
    .valid_o(valid1), .ready_i(1'b1), .data_o(data1), .center_o(center1),
    .sol_o(sol1), .eol_o(eol1), .eof_o(eof1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic s, input logic e,
                          input logic f);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"}, 32'(data_o), 32'(d));
    chk({tag, "_center"}, 32'(center_o), 32'(d));
    chk({tag, "_flags"}, 32'({sol_o, eol_o, eof_o}), 32'({s, e, f}));
  endtask

  // One 4-pixel line with ready_i held high; six beats on consecutive cycles.
  task automatic run_line(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic exp_eof);
    s_valid_i = 1'b1; s_data_i = a;
    step(); chk_beat({tag, "_b0"}, a, 1'b1, 1'b0, 1'b0);
    chk({tag, "_rdy_repl"}, 32'(s_ready_o), 32'd0);
    s_data_i = b;
    step(); chk_beat({tag, "_b1"}, a, 1'b0, 1'b0, 1'b0);
    chk({tag, "_rdy_pass"}, 32'(s_ready_o), 32'd1);
    step(); chk_beat({tag, "_b2"}, b, 1'b0, 1'b0, 1'b0);
    s_data_i = c;
    step(); chk_beat({tag, "_b3"}, c, 1'b0, 1'b0, 1'b0);
    s_data_i = d;
    step(); chk_beat({tag, "_b4"}, d, 1'b0, 1'b0, 1'b0);
    s_valid_i = 1'b0;
    step(); chk_beat({tag, "_b5"}, d, 1'b0, 1'b1, exp_eof);
    step(); chk({tag, "_idle"}, 32'(valid_o), 32'd0);
  endtask

  logic [7:0] pix [16];
  logic [7:0] exp_d [$];
  logic [2:0] exp_f [$];
  logic       acc, bt;
  int         pi;

  initial begin
    rst_n = 1'b0; s_valid_i = 1'b0; s_data_i = '0; ready_i = 1'b1;
    s_valid1 = 1'b0; s_data1 = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // reset state
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_flags", 32'({sol_o, eol_o, eof_o}), 32'd0);
    chk("rst_ready", 32'(s_ready_o), 32'd1);

    // T1: row 0 of frame, then row 1 ends the frame
    run_line("t1", 8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    run_line("t1r1", 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);

    // T4: second frame, eof only on the last line
    run_line("t4r0", 8'd255, 8'd0, 8'd128, 8'd77, 1'b0);
    run_line("t4r1", 8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
    chk("t4_row_wrap", 32'(dut.row_cnt), 32'd0);

    // T2: single-pixel image on the W=1 instance
    s_valid1 = 1'b1; s_data1 = 8'd7;
    step(); s_valid1 = 1'b0;
    chk("t2_b0", 32'({valid1, data1, sol1, eol1, eof1}), 32'({1'b1, 8'd7, 3'b100}));
    step();
    chk("t2_b1", 32'({valid1, data1, sol1, eol1, eof1}), 32'({1'b1, 8'd7, 3'b000}));
    step();
    chk("t2_b2", 32'({valid1, data1, center1, sol1, eol1, eof1}),
        32'({1'b1, 8'd7, 8'd7, 3'b011}));
    step();
    chk("t2_idle", 32'({valid1, s_ready1}), 32'({1'b0, 1'b1}));

    // T3: downstream stall while beat 20 is presented
    s_valid_i = 1'b1; s_data_i = 8'd10;
    step(); chk_beat("t3_b0", 8'd10, 1'b1, 1'b0, 1'b0);
    s_data_i = 8'd20;
    step(); chk_beat("t3_b1", 8'd10, 1'b0, 1'b0, 1'b0);
    step(); chk_beat("t3_b2", 8'd20, 1'b0, 1'b0, 1'b0);
    s_data_i = 8'd30; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("t3_hold", 8'd20, 1'b0, 1'b0, 1'b0);
      chk("t3_hold_rdy", 32'(s_ready_o), 32'd0);
    end
    ready_i = 1'b1;
    step(); chk_beat("t3_b3", 8'd30, 1'b0, 1'b0, 1'b0);
    s_data_i = 8'd40;
    step(); chk_beat("t3_b4", 8'd40, 1'b0, 1'b0, 1'b0);
    s_valid_i = 1'b0;
    step(); chk_beat("t3_b5", 8'd40, 1'b0, 1'b1, 1'b0);

    // T5: async reset mid-line drops the partial line
    s_valid_i = 1'b1; s_data_i = 8'd1;
    step(); s_data_i = 8'd2;
    step(); step();
    chk("t5_pre", 32'(data_o), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async", 32'({valid_o, data_o, center_o, sol_o, eol_o, eof_o}), 32'd0);
    s_valid_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
    s_valid_i = 1'b1; s_data_i = 8'd99;
    step(); chk_beat("t5_b0", 8'd99, 1'b1, 1'b0, 1'b0);
    s_valid_i = 1'b0;
    step(); chk_beat("t5_b1", 8'd99, 1'b0, 1'b0, 1'b0);

    // T6: random valid/ready against a padded-line scoreboard (two frames)
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 4; k++) pix[l*4+k] = 8'($urandom_range(0, 255));
      exp_d.push_back(pix[l*4]);   exp_f.push_back(3'b100);
      for (int k = 0; k < 4; k++) begin
        exp_d.push_back(pix[l*4+k]); exp_f.push_back(3'b000);
      end
      exp_d.push_back(pix[l*4+3]); exp_f.push_back((l % 2 == 1) ? 3'b011 : 3'b010);
    end
    pi = 0;
    for (int cyc = 0; cyc < 2000 && exp_d.size() > 0; cyc++) begin
      ready_i = ($urandom_range(0, 9) < 7);
      if (!s_valid_i && pi < 16 && $urandom_range(0, 1) == 1) begin
        s_valid_i = 1'b1;
        s_data_i  = pix[pi];
      end
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      bt  = valid_o && ready_i;
      if (bt) begin
        if (exp_d.size() == 0) begin
          chk("t6_extra_beat", 32'd1, 32'd0);
        end else begin
          chk("t6_data", 32'(data_o), 32'(exp_d[0]));
          chk("t6_center", 32'(center_o), 32'(exp_d[0]));
          chk("t6_flags", 32'({sol_o, eol_o, eof_o}), 32'(exp_f[0]));
          void'(exp_d.pop_front());
          void'(exp_f.pop_front());
        end
      end
      step();
      if (acc) begin
        s_valid_i = 1'b0;
        pi++;
      end
    end
    chk("t6_all_beats", 32'(exp_d.size()), 32'd0);
    chk("t6_all_pixels", 32'(pi), 32'd16);
    ready_i = 1'b1;
    step(); step();
    chk("t6_drained", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
